pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 12: width of the control bundle (write enables, ALU control, cond, flags, Rd).
REQ-002 SHALL have parameter DATA_W, default 96: width of the data bundle (three 32-bit operands).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  in  1  synchronous discard of all held entries (branch or exception squash).
REQ-006 SHALL have port in_valid  in  1  upstream entry present.
REQ-007 SHALL have port in_ready  out  1  block accepts an entry this cycle.
REQ-008 SHALL have port in_ctrl  in  CTRL_W  upstream control bundle.
REQ-009 SHALL have port in_data  in  DATA_W  upstream data bundle.
REQ-010 SHALL have port out_valid  out  1  downstream entry present.
REQ-011 SHALL have port out_ready  in  1  downstream accepts the entry this cycle.
REQ-012 SHALL have port out_ctrl  out  CTRL_W  control bundle of the head entry.
REQ-013 SHALL have port out_data  out  DATA_W  data bundle of the head entry.

Function
REQ-014 SHALL accept an entry on in_fire = in_valid & in_ready, and SHALL release one on out_fire = out_valid & out_ready.
REQ-015 SHALL hold two entry slots, main and skid, tracked by a 3-state FSM: EMPTY, FULL (main only), SKID (main and skid).
REQ-016 SHALL drive in_ready = 1 in EMPTY and FULL and 0 in SKID, decoded from registered state only, with no combinational path from out_ready.
REQ-017 SHALL drive out_valid = 1 in FULL and SKID, with out_ctrl/out_data taken from main.
REQ-018 SHALL force out_ctrl to all zeros whenever out_valid = 0, so bubbles never assert write enables; out_data SHALL hold its last value.
REQ-019 EMPTY: in_fire loads main and moves to FULL, giving 1-cycle latency from input to output.
REQ-020 FULL: in_fire & out_fire loads main and stays FULL; out_fire alone moves to EMPTY; in_fire alone loads skid and moves to SKID; neither holds.
REQ-021 SKID: out_fire copies skid into main and moves to FULL; otherwise holds; no input is accepted.
REQ-022 SHALL deliver entries in strict acceptance order, with no loss and no duplication.
REQ-023 flush = 1 SHALL move the FSM to EMPTY at the next edge, discarding main, skid and any input offered that cycle, regardless of in_valid or out_ready.
REQ-024 flush SHALL take priority over all handshake transitions; reset SHALL take priority over flush.
REQ-025 Back-to-back streaming with out_ready held at 1 SHALL sustain one entry per cycle.

Reset
REQ-026 reset sampled high SHALL set state EMPTY, main and skid ctrl/data to 0, out_valid 0, out_ctrl 0 and out_data 0; in_ready SHALL read 1 from the first cycle after reset deasserts.
REQ-027 reset asserted mid-transfer SHALL discard all entries; inputs offered while reset is high SHALL be ignored.

Configuration
REQ-028 With macro PIPE_SKID_STATS_EN defined, the block SHALL add output stall_cnt[31:0] and output flush_cnt[15:0]:
- stall_cnt increments each cycle with out_valid & ~out_ready.
- flush_cnt increments each flush cycle in which at least one valid entry is discarded.
- Both saturate at all-ones and clear on reset.
REQ-029 Without PIPE_SKID_STATS_EN, these ports and their counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Streaming test:
- stimulus: reset, then ctrl 0x001..0x005 on 5 consecutive cycles, out_ready = 1.
- response: out_valid goes high 1 cycle after the first accept; ctrl 0x001..0x005 appear in order on consecutive cycles; in_ready stays 1.
REQ-031 Backpressure test:
- stimulus: out_ready = 0 while offering A = 0x0AA then B = 0x0BB.
- response: state reaches SKID; in_ready = 0; out_ctrl holds 0x0AA.
- then raise out_ready: 0x0AA then 0x0BB are delivered, and in_ready returns to 1 one cycle after the first out_fire.
REQ-032 Flush test:
- stimulus: in SKID, assert flush for one cycle together with in_valid and data 0x0CC.
- response: next cycle out_valid = 0, out_ctrl = 0, in_ready = 1; 0x0CC is never output; with stats enabled, flush_cnt = 1.
REQ-033 Reset test:
- stimulus: assert reset in FULL with out_ctrl 0x3FF.
- response: after the edge, out_valid = 0 and out_ctrl = 0; while reset is high, an offered 0x123 is not captured.
REQ-034 Stall test (stats enabled):
- stimulus: hold out_valid = 1 with out_ready = 0 for 7 cycles.
- response: stall_cnt = 7.
- preload stall_cnt = 0xFFFFFFFE and stall 3 more cycles: stall_cnt = 0xFFFFFFFF.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for a pipeline stage boundary: main + skid slots, in_ready from registered state only.
// Optional statistics counters are compiled in with `define PIPE_SKID_STATS_EN.
module pipe_skid_reg #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_SKID_STATS_EN
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`else
  output logic [DATA_W-1:0] out_data
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_data;
  assign in_fire   = in_valid & in_ready_r;
  assign out_fire  = out_valid_r & out_ready;

  // Bubbles must never carry live write enables downstream.
  always_comb begin
    out_ctrl = {CTRL_W{1'b0}};
    if (out_valid_r) begin
      out_ctrl = main_ctrl;
    end else begin
      out_ctrl = {CTRL_W{1'b0}};
    end
  end

  // Slot FSM; handshake flags are registered copies of the state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      main_ctrl   <= {CTRL_W{1'b0}};
      main_data   <= {DATA_W{1'b0}};
      skid_ctrl   <= {CTRL_W{1'b0}};
      skid_data   <= {DATA_W{1'b0}};
    end else if (flush) begin
      state       <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_ctrl   <= in_ctrl;
            main_data   <= in_data;
            state       <= FULL;
            out_valid_r <= 1'b1;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_fire) begin
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            state      <= SKID;
            in_ready_r <= 1'b0;
          end else if (out_fire) begin
            state       <= EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        SKID: begin
          if (out_fire) begin
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            state      <= FULL;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STATS_EN
  // Saturating stall and squash counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (out_valid_r && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush && out_valid_r && flush_cnt != 16'hFFFF) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a queue model of the two slots is updated each edge
// from the bench's own stimulus and compared against the DUT on the falling edge.
module tb_pipe_skid_reg;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [11:0]  in_ctrl, out_ctrl;
  logic [95:0]  in_data, out_data;
`ifdef PIPE_SKID_STATS_EN
  logic [31:0]  stall_cnt;
  logic [15:0]  flush_cnt;
  logic [31:0]  stall_m;
  logic [15:0]  flush_m;
`endif

  typedef struct {
    logic [11:0] c;
    logic [95:0] d;
  } ent_t;

  ent_t        q[$];
  logic [95:0] main_m;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.CTRL_W(12), .DATA_W(96)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
`ifdef PIPE_SKID_STATS_EN
    .out_data(out_data), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
    .out_data(out_data)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge, update the model from the stimulus that edge saw, then compare.
  task automatic cycle();
    int   n;
    ent_t e;
    @(posedge clk);
    n = q.size();
    if (reset) begin
      q.delete();
      main_m = 96'd0;
`ifdef PIPE_SKID_STATS_EN
      stall_m = 32'd0;
      flush_m = 16'd0;
`endif
    end else begin
`ifdef PIPE_SKID_STATS_EN
      if (n > 0 && !out_ready && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
      if (flush && n > 0 && flush_m != 16'hFFFF) flush_m = flush_m + 16'd1;
`endif
      if (flush) begin
        q.delete();
      end else begin
        if (n > 0 && out_ready) void'(q.pop_front());
        if (in_valid && n < 2) begin
          e.c = in_ctrl;
          e.d = in_data;
          q.push_back(e);
        end
      end
    end
    if (q.size() > 0) main_m = q[0].d;
    @(negedge clk);
    check("out_valid", {127'd0, out_valid}, {127'd0, q.size() > 0});
    check("in_ready", {127'd0, in_ready}, {127'd0, q.size() < 2});
    check("out_ctrl", {116'd0, out_ctrl}, (q.size() > 0) ? {116'd0, q[0].c} : 128'd0);
    check("out_data", {32'd0, out_data}, {32'd0, main_m});
`ifdef PIPE_SKID_STATS_EN
    check("stall_cnt", {96'd0, stall_cnt}, {96'd0, stall_m});
    check("flush_cnt", {112'd0, flush_cnt}, {112'd0, flush_m});
`endif
  endtask

  task automatic offer(input logic [11:0] c);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = 12'd0; in_data = 96'd0; main_m = 96'd0;
`ifdef PIPE_SKID_STATS_EN
    stall_m = 32'd0; flush_m = 16'd0;
`endif
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      offer(i[11:0]);
      cycle();
      check("stream_head", {116'd0, out_ctrl}, {116'd0, i[11:0]});
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // Backpressure into the skid slot.
    out_ready = 1'b0;
    offer(12'h0AA);
    cycle();
    offer(12'h0BB);
    cycle();
    in_valid = 1'b0;
    cycle();
    check("bp_hold_ctrl", {116'd0, out_ctrl}, {116'd0, 12'h0AA});
    check("bp_in_ready", {127'd0, in_ready}, 128'd0);
    out_ready = 1'b1;
    cycle();
    check("bp_second", {116'd0, out_ctrl}, {116'd0, 12'h0BB});
    cycle();
    cycle();

    // Flush while in SKID, with a competing input.
    out_ready = 1'b0;
    offer(12'h011);
    cycle();
    offer(12'h022);
    cycle();
    flush = 1'b1;
    offer(12'h0CC);
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_ctrl", {116'd0, out_ctrl}, 128'd0);
    check("flush_ready", {127'd0, in_ready}, 128'd1);
`ifdef PIPE_SKID_STATS_EN
    check("flush_cnt_one", {112'd0, flush_cnt}, 128'd1);
`endif
    out_ready = 1'b1;
    cycle();
    cycle();

    // Reset mid-transfer ignores the input offered under reset.
    out_ready = 1'b0;
    offer(12'h3FF);
    cycle();
    check("rst_pre_ctrl", {116'd0, out_ctrl}, {116'd0, 12'h3FF});
    reset = 1'b1;
    offer(12'h123);
    cycle();
    check("rst_valid", {127'd0, out_valid}, 128'd0);
    check("rst_ctrl", {116'd0, out_ctrl}, 128'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    cycle();
    check("rst_no_capture", {127'd0, out_valid}, 128'd0);

    // Stall for seven cycles.
    offer(12'h055);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
`ifdef PIPE_SKID_STATS_EN
    check("stall_seven", {96'd0, stall_cnt}, 128'd7);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    stall_m = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) cycle();
    check("stall_sat", {96'd0, stall_cnt}, {96'd0, 32'hFFFF_FFFF});
`endif
    out_ready = 1'b1;
    cycle();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ctrl   = 12'($urandom);
      in_data   = {$urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
